// File: rtl/fw_wishbone_sram_ctrl_multi.sv
// fw_wishbone_sram_ctrl_multi
//   Round-robin arbiter that puts N_PORTS Wishbone-classic target ports onto
//   one single-port synchronous SRAM. The SRAM has a 1-cycle read latency and
//   a byte write mask. A word index at or beyond MEM_WORDS ends with an error
//   termination and never reaches the SRAM.
//
// Ports
//   clock, reset_n       clock (rising edge) and async active-low reset
//   t_adr/t_dat_w/t_sel  per-port byte address, write data, byte selects
//   t_cyc/t_stb/t_we     per-port cycle, strobe, write enable
//   t_dat_r/t_ack/t_err  per-port read data and terminations (one cycle)
//   sram_*               SRAM macro interface (ce/we active high)
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | pick the next requesting port at or after rr_ptr
// ACCESS | drive the SRAM for the granted port and register the outcome
// RESP   | present ack/err (and read data) to the granted port
module fw_wishbone_sram_ctrl_multi #(
  parameter int N_PORTS   = 2,
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int MEM_WORDS = 1024,
  localparam int SEL_W         = DAT_WIDTH / 8,
  localparam int WORD_LSB      = (SEL_W > 1) ? $clog2(SEL_W) : 0,
  localparam int MEM_ADR_WIDTH = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [N_PORTS*ADR_WIDTH-1:0] t_adr,
  input  logic [N_PORTS*DAT_WIDTH-1:0] t_dat_w,
  output logic [N_PORTS*DAT_WIDTH-1:0] t_dat_r,
  input  logic [N_PORTS-1:0]           t_cyc,
  input  logic [N_PORTS-1:0]           t_stb,
  input  logic [N_PORTS-1:0]           t_we,
  input  logic [N_PORTS*SEL_W-1:0]     t_sel,
  output logic [N_PORTS-1:0]           t_ack,
  output logic [N_PORTS-1:0]           t_err,
  output logic [MEM_ADR_WIDTH-1:0]     sram_addr,
  output logic                         sram_ce,
  output logic                         sram_we,
  output logic [SEL_W-1:0]             sram_wmask,
  output logic [DAT_WIDTH-1:0]         sram_wdata,
  input  logic [DAT_WIDTH-1:0]         sram_rdata
);

  localparam int GNT_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int IDX_W = ADR_WIDTH - WORD_LSB;
  localparam logic [IDX_W:0] MEM_WORDS_C = (IDX_W + 1)'(MEM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [GNT_W-1:0] gnt, gnt_nxt;
  logic [GNT_W-1:0] rr_ptr, rr_ptr_nxt;
  logic             res_ack, res_ack_nxt;
  logic             res_err, res_err_nxt;
  logic             res_rd, res_rd_nxt;

  logic [N_PORTS-1:0] req;
  logic               g_req, g_we, in_range;
  logic [IDX_W-1:0]   g_idx;
  logic [DAT_WIDTH-1:0] g_dat;
  logic [SEL_W-1:0]   g_sel;
  logic               pick_found;
  logic [GNT_W-1:0]   pick;

  // Byte-lane address bits are meaningless to a word-wide SRAM.
  logic [N_PORTS*ADR_WIDTH-1:0] unused_t_adr;
  assign unused_t_adr = t_adr;

  assign req = t_cyc & t_stb;

  // Request and payload of the currently granted port.
  always_comb begin
    g_req = 1'b0;
    g_we  = 1'b0;
    g_idx = '0;
    g_dat = '0;
    g_sel = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gnt == GNT_W'(i)) begin
        g_req = req[i];
        g_we  = t_we[i];
        g_idx = t_adr[i*ADR_WIDTH+WORD_LSB +: IDX_W];
        g_dat = t_dat_w[i*DAT_WIDTH +: DAT_WIDTH];
        g_sel = t_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  assign in_range = {1'b0, g_idx} < MEM_WORDS_C;

  // Round-robin pick: first requester at or above rr_ptr, otherwise wrap to
  // the lowest requester below it.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!pick_found && req[i] && (GNT_W'(i) >= rr_ptr)) begin
        pick_found = 1'b1;
        pick       = GNT_W'(i);
      end
    end
    for (int i = 0; i < N_PORTS; i++) begin
      if (!pick_found && req[i]) begin
        pick_found = 1'b1;
        pick       = GNT_W'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      gnt     <= '0;
      rr_ptr  <= '0;
      res_ack <= 1'b0;
      res_err <= 1'b0;
      res_rd  <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      rr_ptr  <= rr_ptr_nxt;
      res_ack <= res_ack_nxt;
      res_err <= res_err_nxt;
      res_rd  <= res_rd_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    rr_ptr_nxt  = rr_ptr;
    res_ack_nxt = res_ack;
    res_err_nxt = res_err;
    res_rd_nxt  = res_rd;
    sram_ce     = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = '0;
    sram_wmask  = '0;
    sram_wdata  = '0;
    t_ack       = '0;
    t_err       = '0;
    t_dat_r     = '0;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          gnt_nxt    = pick;
          rr_ptr_nxt = (pick == GNT_W'(N_PORTS - 1)) ? '0 : pick + GNT_W'(1);
          state_nxt  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // A dropped request leaves both flags clear: RESP then stays silent.
        res_ack_nxt = g_req & in_range;
        res_err_nxt = g_req & ~in_range;
        res_rd_nxt  = ~g_we;
        if (g_req && in_range) begin
          sram_ce    = 1'b1;
          sram_we    = g_we;
          sram_addr  = g_idx[MEM_ADR_WIDTH-1:0];
          sram_wdata = g_dat;
          if (g_we) sram_wmask = g_sel;
        end
        state_nxt = S_RESP;
      end
      S_RESP: begin
        for (int i = 0; i < N_PORTS; i++) begin
          if (gnt == GNT_W'(i)) begin
            t_ack[i] = res_ack;
            t_err[i] = res_err;
            if (res_ack && res_rd) t_dat_r[i*DAT_WIDTH +: DAT_WIDTH] = sram_rdata;
          end
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fw_wishbone_sram_ctrl_multi.sv
// Bench for fw_wishbone_sram_ctrl_multi (2 ports, 32-bit data, 1000 words).
// Contains a behavioural SRAM macro and a word-level reference memory.
module tb_fw_wishbone_sram_ctrl_multi;
  localparam int NP = 2, AW = 32, DW = 32, MW = 1000, SW = 4, MAW = 10;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [NP*AW-1:0] t_adr;
  logic [NP*DW-1:0] t_dat_w, t_dat_r;
  logic [NP-1:0]    t_cyc, t_stb, t_we, t_ack, t_err;
  logic [NP*SW-1:0] t_sel;
  logic [MAW-1:0]   sram_addr;
  logic             sram_ce, sram_we;
  logic [SW-1:0]    sram_wmask;
  logic [DW-1:0]    sram_wdata, sram_rdata;

  always #5 clock = ~clock;

  fw_wishbone_sram_ctrl_multi #(.N_PORTS(NP), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .MEM_WORDS(MW)) dut (
    .clock(clock), .reset_n(reset_n), .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
    .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_sel(t_sel), .t_ack(t_ack), .t_err(t_err),
    .sram_addr(sram_addr), .sram_ce(sram_ce), .sram_we(sram_we), .sram_wmask(sram_wmask),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata));

  // Behavioural SRAM macro: byte-masked write, 1-cycle read latency.
  logic [DW-1:0] sram_mem [0:1023];
  logic mem_clr = 1'b1;
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= '0;
    end else if (sram_ce && sram_we) begin
      for (int b = 0; b < SW; b++)
        if (sram_wmask[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
    end
    if (sram_ce && !sram_we) sram_rdata <= sram_mem[sram_addr];
  end

  int ce_oor_cnt = 0;
  always @(negedge clock) if (sram_ce && int'(sram_addr) >= MW) ce_oor_cnt <= ce_oor_cnt + 1;

  logic [31:0] ref_mem [0:MW-1];
  int n_vec = 0, n_mis = 0;

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          ack;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(int port, bit we, logic [31:0] adr, logic [31:0] dat,
                              logic [3:0] sel, bit ack, logic [31:0] rd);
    vec_t v;
    v.port = port; v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.ack = ack; v.rd = rd;
    return v;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int p, input bit we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    t_adr[p*AW +: AW] = adr;
    t_dat_w[p*DW +: DW] = dat;
    t_sel[p*SW +: SW] = sel;
    t_we[p] = we;
    t_cyc[p] = 1'b1;
    t_stb[p] = 1'b1;
  endtask

  // One transaction on port p, started with the FSM idle; snapshots the full
  // response buses at termination and the SRAM controls in the ACCESS cycle.
  task automatic xact(input int p, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [1:0] ab, output logic [1:0] eb,
                      output logic [63:0] db, output int lat, output logic ce_a,
                      output logic [MAW-1:0] addr_a, output logic [3:0] mask_a);
    ab = '0; eb = '0; db = '0; lat = 0; ce_a = 1'b0; addr_a = '0; mask_a = '0;
    drive(p, we, adr, dat, sel);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c == 1) begin ce_a = sram_ce; addr_a = sram_addr; mask_a = sram_wmask; end
      if ((t_ack | t_err) != '0) begin
        ab = t_ack; eb = t_err; db = t_dat_r; lat = c;
        break;
      end
    end
    t_cyc[p] = 1'b0;
    t_stb[p] = 1'b0;
    @(negedge clock);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ack"}, 64'(t_ack), 64'd0);
    chk({nm, "_err"}, 64'(t_err), 64'd0);
    chk({nm, "_dat_r"}, 64'(t_dat_r), 64'd0);
    chk({nm, "_ce"}, 64'(sram_ce), 64'd0);
    chk({nm, "_we"}, 64'(sram_we), 64'd0);
    chk({nm, "_wmask"}, 64'(sram_wmask), 64'd0);
    chk({nm, "_wdata"}, 64'(sram_wdata), 64'd0);
    chk({nm, "_addr"}, 64'(sram_addr), 64'd0);
  endtask

  vec_t vecs [14];
  logic [1:0] ab, eb;
  logic [63:0] db;
  int lat;
  logic ce_a;
  logic [MAW-1:0] addr_a;
  logic [3:0] mask_a;
  logic [1:0] exp2;
  bit act [2], pend [2], rwe [2], inr;
  int rword [2];
  logic [31:0] rdat [2], exp_rd;
  logic [3:0] rsel [2];

  initial begin
    for (int i = 0; i < MW; i++) ref_mem[i] = '0;
    vecs[0]  = mk(0, 1, 32'h10,  32'hDEADBEEF, 4'hF, 1, 32'h0);
    vecs[1]  = mk(0, 0, 32'h10,  32'h0,        4'hF, 1, 32'hDEADBEEF);
    vecs[2]  = mk(1, 1, 32'h20,  32'h11223344, 4'hF, 1, 32'h0);
    vecs[3]  = mk(1, 1, 32'h20,  32'hAABBCCDD, 4'h5, 1, 32'h0);
    vecs[4]  = mk(0, 0, 32'h20,  32'h0,        4'hF, 1, 32'h11BB33DD);
    vecs[5]  = mk(0, 0, 32'hFA0, 32'h0,        4'hF, 0, 32'h0);
    vecs[6]  = mk(1, 1, 32'hFA0, 32'hCAFEF00D, 4'hF, 0, 32'h0);
    vecs[7]  = mk(0, 1, 32'hF9C, 32'h12345678, 4'hF, 1, 32'h0);
    vecs[8]  = mk(1, 0, 32'hF9C, 32'h0,        4'hF, 1, 32'h12345678);
    vecs[9]  = mk(0, 1, 32'h12,  32'h55555555, 4'h0, 1, 32'h0);
    vecs[10] = mk(1, 0, 32'h13,  32'h0,        4'hF, 1, 32'hDEADBEEF);
    vecs[11] = mk(0, 0, 32'h1000, 32'h0,       4'hF, 0, 32'h0);
    vecs[12] = mk(0, 1, 32'h1000, 32'hBAD0BAD0, 4'hF, 0, 32'h0);
    vecs[13] = mk(1, 0, 32'h0,   32'h0,        4'hF, 1, 32'h0);

    // Reset state, with both ports already requesting reads.
    t_adr = '0; t_dat_w = '0; t_sel = '0; t_we = '0; t_cyc = '0; t_stb = '0;
    drive(0, 0, 32'h40, 32'h0, 4'hF);
    drive(1, 0, 32'h44, 32'h0, 4'hF);
    @(negedge clock);
    @(negedge clock);
    chk_quiet("reset");

    // Continuous requests from reset: acks every 3 cycles, ports alternating.
    mem_clr = 1'b0;
    reset_n = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clock);
      exp2 = (c % 3 == 2) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk($sformatf("rr_ack_c%0d", c), 64'(t_ack), 64'(exp2));
      chk($sformatf("rr_err_c%0d", c), 64'(t_err), 64'd0);
    end
    t_cyc = '0; t_stb = '0;
    @(negedge clock);

    // Directed vectors.
    for (int i = 0; i < 14; i++) begin
      xact(vecs[i].port, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
           ab, eb, db, lat, ce_a, addr_a, mask_a);
      chk($sformatf("vec%0d_ack", i), 64'(ab), 64'(vecs[i].ack) << vecs[i].port);
      chk($sformatf("vec%0d_err", i), 64'(eb), 64'(!vecs[i].ack) << vecs[i].port);
      chk($sformatf("vec%0d_rdata", i), db, 64'(vecs[i].rd) << (vecs[i].port * DW));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_ce", i), 64'(ce_a), 64'(vecs[i].ack));
      if (vecs[i].ack) begin
        chk($sformatf("vec%0d_addr", i), 64'(addr_a), 64'(vecs[i].adr >> 2));
        chk($sformatf("vec%0d_mask", i), 64'(mask_a), vecs[i].we ? 64'(vecs[i].sel) : 64'd0);
        if (vecs[i].we)
          ref_mem[int'(vecs[i].adr >> 2)] = merge(ref_mem[int'(vecs[i].adr >> 2)], vecs[i].dat, vecs[i].sel);
      end
    end

    // Abort: stb dropped during ACCESS.
    drive(0, 0, 32'h10, 32'h0, 4'hF);
    @(negedge clock);
    chk("abort_ce_before_drop", 64'(sram_ce), 64'd1);
    t_stb[0] = 1'b0;
    #1;
    chk("abort_ce", 64'(sram_ce), 64'd0);
    @(negedge clock);
    chk("abort_ack", 64'(t_ack), 64'd0);
    chk("abort_err", 64'(t_err), 64'd0);
    t_cyc[0] = 1'b0;
    @(negedge clock);
    xact(1, 0, 32'h20, 32'h0, 4'hF, ab, eb, db, lat, ce_a, addr_a, mask_a);
    chk("after_abort_latency", 64'(lat), 64'd2);
    chk("after_abort_rdata", db, {32'h11BB33DD, 32'h0});

    // Reset while in ACCESS: outputs clear at once, transaction dropped,
    // arbitration restarts at port 0.
    drive(0, 0, 32'h10, 32'h0, 4'hF);
    @(negedge clock);
    chk("rst_mid_ce_before", 64'(sram_ce), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_quiet("rst_mid");
    t_cyc = '0; t_stb = '0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      chk($sformatf("rst_mid_silent_c%0d", c), 64'({t_ack, t_err}), 64'd0);
    end
    drive(0, 0, 32'h10, 32'h0, 4'hF);
    drive(1, 0, 32'h20, 32'h0, 4'hF);
    @(negedge clock);
    @(negedge clock);
    chk("rst_mid_first_ack", 64'(t_ack), 64'b01);
    chk("rst_mid_first_data", 64'(t_dat_r), {32'h0, 32'hDEADBEEF});
    t_cyc = '0; t_stb = '0;
    @(negedge clock);

    // Randomised rounds, ports on disjoint words so order is irrelevant.
    for (int r = 0; r < 60; r++) begin
      for (int p = 0; p < 2; p++) begin
        act[p] = ($urandom_range(0, 3) != 0);
        rwe[p] = $urandom_range(0, 1) != 0;
        rsel[p] = 4'($urandom_range(0, 15));
        rdat[p] = $urandom;
        rword[p] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(MW, 2047))
                                               : int'($urandom_range(0, MW / 2 - 1)) * 2 + p;
      end
      if (!act[0] && !act[1]) act[0] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        pend[p] = act[p];
        if (act[p]) drive(p, rwe[p], 32'(rword[p] * 4 + int'($urandom_range(0, 3))), rdat[p], rsel[p]);
      end
      for (int c = 1; c <= 10; c++) begin
        @(negedge clock);
        for (int p = 0; p < 2; p++) begin
          if (pend[p] && (t_ack[p] || t_err[p])) begin
            inr = rword[p] < MW;
            exp_rd = '0;
            if (inr && !rwe[p]) exp_rd = ref_mem[rword[p]];
            chk("rnd_ack", 64'(t_ack[p]), 64'(inr));
            chk("rnd_err", 64'(t_err[p]), 64'(!inr));
            chk("rnd_rdata", 64'(t_dat_r[p*DW +: DW]), 64'(exp_rd));
            chk("rnd_latency_bound", 64'(c <= 5), 64'd1);
            if (inr && rwe[p]) ref_mem[rword[p]] = merge(ref_mem[rword[p]], rdat[p], rsel[p]);
            t_cyc[p] = 1'b0;
            t_stb[p] = 1'b0;
            pend[p] = 1'b0;
          end else if (!pend[p]) begin
            chk("rnd_idle_port", 64'({t_ack[p], t_err[p]}), 64'd0);
          end
        end
        if (!pend[0] && !pend[1]) break;
      end
      chk("rnd_done", 64'({pend[0], pend[1]}), 64'd0);
      t_cyc = '0; t_stb = '0;
      @(negedge clock);
    end

    chk("ce_out_of_range", 64'(ce_oor_cnt), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/fw_wishbone_sram_ctrl_multi.md
Name: fw_wishbone_sram_ctrl_multi

Overview:
Parametrised Wishbone-classic target that arbitrates N_PORTS initiator ports onto one single-port synchronous SRAM macro with 1-cycle read latency and byte write mask. It is the multi-port, width-generic successor to the single-port SRAM controller. It sits between bus masters (CPU instruction/data, DMA) and an on-chip SRAM. Arbitration is round-robin, and out-of-range accesses are reported with err.

Parameters:
N_PORTS, 2, number of Wishbone target ports (1..8)
ADR_WIDTH, 32, Wishbone byte-address width
DAT_WIDTH, 32, data width (multiple of 8: 8/16/32/64)
MEM_WORDS, 1024, SRAM depth in DAT_WIDTH words; need not be a power of 2
(localparams: SEL_W=DAT_WIDTH/8; WORD_LSB=clog2(SEL_W); MEM_ADR_WIDTH=clog2(MEM_WORDS), min 1)

Ports:
clock  in  1  clock; everything is sampled on the rising edge
reset_n  in  1  asynchronous active-low reset
t_adr  in  N_PORTS*ADR_WIDTH  per-port byte address; port i occupies slice [i*ADR_WIDTH +: ADR_WIDTH], and the same slicing applies to every bus below
t_dat_w  in  N_PORTS*DAT_WIDTH  write data
t_dat_r  out  N_PORTS*DAT_WIDTH  read data
t_cyc  in  N_PORTS  cycle valid
t_stb  in  N_PORTS  strobe
t_we  in  N_PORTS  1=write
t_sel  in  N_PORTS*SEL_W  byte selects
t_ack  out  N_PORTS  normal termination
t_err  out  N_PORTS  error termination (word index >= MEM_WORDS)
sram_addr  out  MEM_ADR_WIDTH  word address
sram_ce  out  1  chip enable, active high
sram_we  out  1  write enable, active high
sram_wmask  out  SEL_W  byte write mask
sram_wdata  out  DAT_WIDTH  write data
sram_rdata  in  DAT_WIDTH  read data, valid the cycle after a ce&!we cycle

Behaviour:
- Request on port i: req[i]=t_cyc[i]&t_stb[i]. Word index = t_adr[i][ADR_WIDTH-1:WORD_LSB]. in_range = index < MEM_WORDS.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req, grant the first requesting port at or after rr_ptr (wrapping).
  - Register gnt; set rr_ptr <= (gnt+1) mod N_PORTS; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS, decoded combinationally from gnt:
  - If req[gnt]&in_range: sram_ce=1, sram_we=t_we, sram_addr=index[MEM_ADR_WIDTH-1:0], sram_wdata=t_dat_w, sram_wmask=t_sel when writing, else 0.
  - Register the outcome (ack, err, or none if req[gnt] has dropped = abort). Next state RESP.
- RESP:
  - Drive the registered outcome for port gnt only, for exactly one cycle.
  - On a read ack, t_dat_r slice gnt = sram_rdata. Next state IDLE.
- Latency: request visible in cycle 0 (IDLE) gives ack/err in cycle 2. Peak throughput is 1 access per 3 cycles.
- Back-to-back: an initiator that keeps stb high after ack is re-arbitrated in the following IDLE, so no request is lost.
- Out of range: sram_ce stays 0, t_err=1 in RESP, t_ack=0. Writes never alter the SRAM.
- Abort: if the granted port drops cyc or stb during ACCESS, no SRAM op occurs and no ack/err is given. The FSM passes through RESP silently.
- Writes with t_sel=0: a SRAM write cycle occurs with mask 0 and ack is returned. Memory is unchanged.
- Non-granted ports and non-RESP cycles: t_ack=t_err=0 and t_dat_r=0. t_dat_r is also 0 on write acks and err.
- Requests from non-granted ports are held pending (Wishbone stall-by-no-ack). No starvation: each waiting port is served within N_PORTS grants.
- N_PORTS=1 degenerates to a single-port controller, with rr_ptr held at 0.
- Reset (async assert, sync deassert handled upstream):
  - State IDLE, gnt=0, rr_ptr=0.
  - All outputs 0, including sram_ce/sram_we.
- Reset mid-access: the transaction is dropped and no ack is produced after reset releases.

Test Plan:
- Port0 write adr=0x10, dat=0xDEADBEEF, sel=0xF; then read 0x10 -> SRAM write at word 4 in cycle 1; ack in cycle 2; the read returns 0xDEADBEEF with ack 2 cycles after request.
- Byte write: preload 0x11223344 at adr 0x20, write dat=0xAABBCCDD with sel=0x5 -> readback 0x11BB33DD.
- Ports 0 and 1 both request continuously from reset, N_PORTS=2 -> grants alternate 0,1,0,1; each port acks every 6 cycles.
- MEM_WORDS=1000, read adr=0xFA0 (word 1000) -> t_err=1 for one cycle, t_ack=0, sram_ce never asserted; adr=0xF9C (word 999) -> normal ack.
- Port drops stb during ACCESS -> sram_ce=0 that cycle, no ack/err, FSM returns to IDLE in 2 cycles.
- Assert reset_n=0 while in ACCESS -> all outputs 0 immediately; after release, the first request gets an ack 2 cycles later and rr_ptr restarts at 0.
